// File: rtl/student_tlul_socket_1n.sv
// student_tlul_socket_1n: 1:N TL-UL socket with in-order route FIFO and internal error responder.
// Build option STUDENT_TLUL_SOCKET_ERRCNT_EN adds a saturating error-response counter.
package tlul_pkg;
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [0:0]  d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module student_tlul_socket_1n
   import tlul_pkg::*;
#(
   parameter int NUM         = 2,
   parameter int ADDR_WIDTH  = 4,
   parameter int ADDR_OFFSET = 20,
   parameter int CURR_OFFSET = 24,
   parameter int CURR_WIDTH  = 8,
   parameter int CURR_VAL    = 16,
   parameter int MAX_OUT     = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  tl_h2d_t            tl_host_i,
   output tl_d2h_t            tl_host_o,
   input  tl_d2h_t [NUM-1:0]  tl_device_o,
   output tl_h2d_t [NUM-1:0]  tl_device_i,
   output logic [15:0]        err_count_o
);
   localparam int TW = $clog2(NUM + 1);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [TW-1:0] ERR = TW'(NUM);

   logic [TW-1:0]         fifo_q [MAX_OUT];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         cnt_q;
   logic                  err_busy_q;
   logic [7:0]            err_src_q;
   logic [1:0]            err_size_q;
   logic [2:0]            err_op_q;
   logic                  win, full, empty, a_ready, dev_a_ready, accept, pop;
   logic [ADDR_WIDTH-1:0] sel;
   logic [TW-1:0]         tgt, head;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
   endfunction

   assign win     = tl_host_i.a_address[CURR_OFFSET +: CURR_WIDTH] == CURR_WIDTH'(CURR_VAL);
   assign sel     = tl_host_i.a_address[ADDR_OFFSET +: ADDR_WIDTH];
   assign tgt     = (win && int'(sel) < NUM) ? TW'(sel) : ERR;
   assign full    = cnt_q == CW'(MAX_OUT);
   assign empty   = cnt_q == '0;
   assign head    = fifo_q[rd_ptr_q];
   // a_ready looks only at registered state, so a pop never frees a slot in its own cycle
   assign a_ready = !full && ((tgt == ERR) ? !err_busy_q : dev_a_ready);
   assign accept  = tl_host_i.a_valid && a_ready;
   assign pop     = tl_host_o.d_valid && tl_host_i.d_ready;

   always_comb begin
      tl_device_i = '0;
      dev_a_ready = 1'b0;
      for (int i = 0; i < NUM; i++) begin
         if (tgt == TW'(i)) begin
            tl_device_i[i]         = tl_host_i;
            tl_device_i[i].a_valid = tl_host_i.a_valid && !full;
            tl_device_i[i].d_ready = 1'b0;
            dev_a_ready            = tl_device_o[i].a_ready;
         end
         if (!empty && head == TW'(i)) tl_device_i[i].d_ready = tl_host_i.d_ready;
      end
   end

   always_comb begin
      tl_host_o = '0;
      for (int i = 0; i < NUM; i++)
         if (!empty && head == TW'(i)) tl_host_o = tl_device_o[i];
      if (!empty && head == ERR) begin
         tl_host_o.d_valid  = 1'b1;
         tl_host_o.d_opcode = (err_op_q == Get) ? AccessAckData : AccessAck;
         tl_host_o.d_size   = err_size_q;
         tl_host_o.d_source = err_src_q;
         tl_host_o.d_data   = '1;
         tl_host_o.d_error  = 1'b1;
      end
      tl_host_o.a_ready = a_ready;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_busy_q <= 1'b0;
         err_src_q  <= '0;
         err_size_q <= '0;
         err_op_q   <= '0;
      end else begin
         if (accept) wr_ptr_q <= inc(wr_ptr_q);
         if (pop) rd_ptr_q <= inc(rd_ptr_q);
         if (accept && !pop) cnt_q <= cnt_q + CW'(1);
         else if (!accept && pop) cnt_q <= cnt_q - CW'(1);
         if (accept && tgt == ERR) begin
            err_busy_q <= 1'b1;
            err_src_q  <= tl_host_i.a_source;
            err_size_q <= tl_host_i.a_size;
            err_op_q   <= tl_host_i.a_opcode;
         end else if (pop && head == ERR) begin
            err_busy_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) fifo_q[wr_ptr_q] <= tgt;
   end

`ifdef STUDENT_TLUL_SOCKET_ERRCNT_EN
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_cnt_q <= '0;
      else if (accept && tgt == ERR && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
   end
   assign err_count_o = err_cnt_q;
`else
   assign err_count_o = '0;
`endif
endmodule

// File: doc/student_tlul_socket_1n.md
Name: student_tlul_socket_1n

Overview:
Parametrised 1:N TL-UL socket, the successor to the single-cycle student TL-UL mux. It sits between one TL-UL host (the student bus crossbar port) and NUM student devices. It supports multiple outstanding requests with in-order response routing through a route FIFO. Requests that cannot be routed get a TL-UL error response from an internal error responder instead of being dropped.

Parameters:
NUM, 2, number of downstream devices (1..15).
ADDR_WIDTH, 4, width of the device-select address field.
ADDR_OFFSET, 20, LSB position of the device-select field in a_address.
CURR_OFFSET, 24, LSB position of the window-match field in a_address.
CURR_WIDTH, 8, width of the window-match field.
CURR_VAL, 16, value the window-match field must equal for a request to be routable.
MAX_OUT, 4, route FIFO depth, i.e. the maximum number of outstanding requests (power of 2, 1..16).

Ports:
clk_i  input  1  clock.
rst_ni  input  1  asynchronous active-low reset.
tl_host_i  input  tlul_pkg::tl_h2d_t  host request channel A plus d_ready.
tl_host_o  output  tlul_pkg::tl_d2h_t  host response channel D plus a_ready.
tl_device_o  input  tlul_pkg::tl_d2h_t [NUM-1:0]  device responses.
tl_device_i  output  tlul_pkg::tl_h2d_t [NUM-1:0]  device requests.
err_count_o  output  16  saturating count of error responses issued (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Decode: win = (a_address[CURR_OFFSET+:CURR_WIDTH] == CURR_VAL). sel = a_address[ADDR_OFFSET+:ADDR_WIDTH]. tgt = sel if (win && sel < NUM), else ERR (encoded as NUM).
- A-channel, device target:
  - tl_device_i[tgt] carries tl_host_i combinationally, with a_valid = host a_valid && !fifo_full.
  - Every other device sees a_valid = 0 and all other A fields = 0.
  - Host a_ready = device a_ready && !fifo_full.
- A-channel, ERR target: host a_ready = !fifo_full && !err_busy.
- Acceptance: a request is accepted when host a_valid && host a_ready. On acceptance tgt is pushed into the route FIFO. For an ERR request the error slot also latches a_source, a_size and opcode, and err_busy becomes 1.
- D-channel: only the FIFO head target may respond.
  - Head is a device: tl_host_o D fields = tl_device_o[head], and tl_device_i[head].d_ready = host d_ready.
  - Head is ERR: the error slot drives d_valid = 1, d_error = 1, d_source and d_size from the latched values, d_data = all-ones, d_sink = 0. d_opcode = AccessAckData for Get and AccessAck for PutFull/PutPartial.
  - Non-head devices always see d_ready = 0.
  - FIFO empty: host d_valid = 0.
- Pop: the FIFO pops when host d_valid && host d_ready. Popping an ERR entry clears err_busy.
- Latency: zero added cycles on both the A path and the D path (combinational pass-through). One error response is produced at the earliest 1 cycle after acceptance, after all older responses have drained.
- Simultaneous push and pop: occupancy is unchanged. Full-and-pop in the same cycle still blocks the push, because a_ready depends only on registered full.
- Boundaries:
  - FIFO full (MAX_OUT outstanding): a_ready = 0 for all targets.
  - FIFO empty: no D traffic is forwarded.
  - Pointers wrap modulo MAX_OUT.
  - A second ERR request while err_busy stalls until the first error response pops.
- Reset: asynchronous and valid mid-transfer. FIFO pointers and count go to 0, err_busy = 0, err_count_o = 0. Registers therefore imply host d_valid = 0 and all device d_ready = 0. Outstanding device responses arriving after reset are not consumed. System reset covers both sides.
- Widths: the FIFO entry is clog2(NUM+1) bits. The count is clog2(MAX_OUT+1) bits.

Optional Feature:
Macro: STUDENT_TLUL_SOCKET_ERRCNT_EN.
- Defined: err_count_o increments by 1 on each accepted ERR request and saturates at 16'hFFFF.
- Undefined: the counter is not built and err_count_o is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Get to 0x1010_0004 with NUM=2; device 1 returns AccessAckData 0xCAFE_F00D with d_source=3 -> host sees the same response the same cycle, and device 0 sees a_valid=0.
- Get to 0x2000_0000 (window miss), a_source=5 -> host receives d_error=1, AccessAckData, d_data=0xFFFF_FFFF, d_source=5; err_count_o=1 with the macro defined, 0 without.
- Put to 0x1030_0000 (sel=3 >= NUM) -> AccessAck with d_error=1, and no device a_valid asserted.
- Back-to-back requests to dev0, dev1, dev0; dev1 presents d_valid before dev0 -> dev1 is held with d_ready=0, and responses reach the host in order dev0, dev1, dev0.
- MAX_OUT=4, devices never respond -> exactly 4 requests are accepted and the 5th sees a_ready=0. One response then frees one slot, and the next accept happens the following cycle.
- Assert rst_ni low with 3 outstanding requests -> host d_valid=0 and a_ready reflects an empty FIFO immediately (asynchronously); after release a new request is accepted normally.
